// File: rtl/pps_sel_pkg.sv
// Shared types and constants for the PPS timestamp source selector.
package pps_sel_pkg;

    // Selection state: HOLDOVER means the PPS generator free-runs (autonomous).
    typedef enum logic {
        HOLDOVER = 1'b0,
        LOCKED   = 1'b1
    } sel_state_t;

    // 1.1 s at 100 MHz: one missed T2-MI second plus margin.
    localparam int DEFAULT_TIMEOUT_CYC = 110_000_000;

    // Width of a source index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pps_src_qualifier.sv
// Qualifies one timestamp stream: lock, enable, timeout and seconds continuity.
module pps_src_qualifier
    import pps_sel_pkg::*;
#(
    parameter int SEC_W       = 40,
    parameter int QUAL_COUNT  = 4,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ts_valid_i,
    input  logic [SEC_W-1:0] seconds_i,
    input  logic             locked_i,
    input  logic             enable_i,
    output logic             qualified_o,
    output logic             good_ts_o,
    output logic             ts_ok_o
);

    localparam int QC_W  = $clog2(QUAL_COUNT + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [QC_W-1:0]  qual_cnt_q, qual_cnt_d;
    logic [SEC_W-1:0] last_sec_q, last_sec_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             good_q, good_d;
    logic             counting;
    logic             timeout;
    logic             continuous;

    // The timeout only runs once a stream has started counting.
    assign counting   = (qual_cnt_q != '0);
    assign timeout    = counting && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC));
    assign continuous = (seconds_i == last_sec_q + SEC_W'(1));

    // Next-state: disqualifiers first, then the strobe, then the idle timeout.
    always_comb begin
        qual_cnt_d = qual_cnt_q;
        last_sec_d = last_sec_q;
        tmo_cnt_d  = tmo_cnt_q;
        good_d     = 1'b0;
        if (!locked_i || !enable_i) begin
            qual_cnt_d = '0;
            tmo_cnt_d  = '0;
        end else if (ts_valid_i) begin
            last_sec_d = seconds_i;
            tmo_cnt_d  = '0;
            if (timeout || (counting && !continuous)) begin
                // A strobe racing the timeout, or a seconds jump, restarts at 1.
                qual_cnt_d = QC_W'(1);
            end else begin
                good_d = 1'b1;
                if (qual_cnt_q != QC_W'(QUAL_COUNT)) begin
                    qual_cnt_d = qual_cnt_q + QC_W'(1);
                end
            end
        end else if (timeout) begin
            qual_cnt_d = '0;
            tmo_cnt_d  = '0;
        end else if (counting) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    // Qualifier state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            qual_cnt_q <= '0;
            last_sec_q <= '0;
            tmo_cnt_q  <= '0;
            good_q     <= 1'b0;
        end else begin
            qual_cnt_q <= qual_cnt_d;
            last_sec_q <= last_sec_d;
            tmo_cnt_q  <= tmo_cnt_d;
            good_q     <= good_d;
        end
    end

    assign qualified_o = (qual_cnt_q == QC_W'(QUAL_COUNT));
    assign good_ts_o   = good_q;
    // Current strobe would be accepted as good; lets the top refuse to forward
    // a discontinuous or timed-out timestamp even though qualified_o is still set.
    assign ts_ok_o     = ts_valid_i && locked_i && enable_i && !timeout &&
                         (!counting || continuous);

endmodule

// File: rtl/pps_source_selector.sv
// Picks the highest-priority qualified timestamp source for the PPS generator,
// with revertive hold-off switching, holdover mode and a sync LED.
module pps_source_selector
    import pps_sel_pkg::*;
#(
    parameter int NUM_SRC        = 4,
    parameter int SEC_W          = 40,
    parameter int SUBSEC_W       = 32,
    parameter int QUAL_COUNT     = 4,
    parameter int TIMEOUT_CYC    = DEFAULT_TIMEOUT_CYC,
    parameter int SWITCH_HOLDOFF = 3,
    parameter int LED_DIV_W      = 24,
    localparam int IDX_W         = idx_width(NUM_SRC)
) (
    input  logic                        clk_100mhz,
    input  logic                        rst_n,
    input  logic [NUM_SRC-1:0]          src_ts_valid,
    input  logic [NUM_SRC*SEC_W-1:0]    src_seconds,
    input  logic [NUM_SRC*SUBSEC_W-1:0] src_subsec,
    input  logic [NUM_SRC-1:0]          src_sync_locked,
    input  logic [NUM_SRC-1:0]          src_enable,
    input  logic                        force_autonomous,
    output logic                        sel_ts_valid,
    output logic [SEC_W-1:0]            sel_seconds,
    output logic [SUBSEC_W-1:0]         sel_subsec,
    output logic [IDX_W-1:0]            sel_index,
    output logic [NUM_SRC-1:0]          src_qualified,
    output logic                        autonomous_mode,
    output logic                        switch_event,
    output logic                        led_sync
);

    localparam int REV_W = $clog2(SWITCH_HOLDOFF + 1);

    logic [SEC_W-1:0]    sec_arr [NUM_SRC];
    logic [SUBSEC_W-1:0] sub_arr [NUM_SRC];
    logic [NUM_SRC-1:0]  qual;
    logic [NUM_SRC-1:0]  good_ts;
    logic [NUM_SRC-1:0]  ts_ok;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign sec_arr[g] = src_seconds[g*SEC_W +: SEC_W];
        assign sub_arr[g] = src_subsec[g*SUBSEC_W +: SUBSEC_W];

        pps_src_qualifier #(
            .SEC_W       (SEC_W),
            .QUAL_COUNT  (QUAL_COUNT),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_qual (
            .clk_i       (clk_100mhz),
            .rst_ni      (rst_n),
            .ts_valid_i  (src_ts_valid[g]),
            .seconds_i   (sec_arr[g]),
            .locked_i    (src_sync_locked[g]),
            .enable_i    (src_enable[g]),
            .qualified_o (qual[g]),
            .good_ts_o   (good_ts[g]),
            .ts_ok_o     (ts_ok[g])
        );
    end

    sel_state_t          state_q;
    logic [IDX_W-1:0]    active_q;
    logic [IDX_W-1:0]    cand_q;
    logic                cand_vld_q;
    logic [REV_W-1:0]    rev_cnt_q;
    logic                switch_event_q;
    logic                any_qual;
    logic [IDX_W-1:0]    low_idx;

    // Priority encoder: lowest qualified index wins.
    always_comb begin
        any_qual = |qual;
        low_idx  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (qual[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // Selection FSM with failover and revertive hold-off counting.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= HOLDOVER;
            active_q       <= '0;
            cand_q         <= '0;
            cand_vld_q     <= 1'b0;
            rev_cnt_q      <= '0;
            switch_event_q <= 1'b0;
        end else begin
            switch_event_q <= 1'b0;
            case (state_q)
                HOLDOVER: begin
                    rev_cnt_q  <= '0;
                    cand_vld_q <= 1'b0;
                    if (!force_autonomous && any_qual) begin
                        state_q        <= LOCKED;
                        active_q       <= low_idx;
                        switch_event_q <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (force_autonomous || !any_qual) begin
                        state_q        <= HOLDOVER;
                        switch_event_q <= 1'b1;
                        rev_cnt_q      <= '0;
                        cand_vld_q     <= 1'b0;
                    end else if (!qual[active_q]) begin
                        active_q       <= low_idx;
                        switch_event_q <= 1'b1;
                        rev_cnt_q      <= '0;
                        cand_vld_q     <= 1'b0;
                    end else if (low_idx < active_q) begin
                        if (!cand_vld_q || (cand_q != low_idx)) begin
                            // New candidate: its qualifying strobe is not counted.
                            cand_q     <= low_idx;
                            cand_vld_q <= 1'b1;
                            rev_cnt_q  <= '0;
                        end else if (good_ts[low_idx]) begin
                            if (rev_cnt_q == REV_W'(SWITCH_HOLDOFF - 1)) begin
                                active_q       <= low_idx;
                                switch_event_q <= 1'b1;
                                rev_cnt_q      <= '0;
                                cand_vld_q     <= 1'b0;
                            end else begin
                                rev_cnt_q <= rev_cnt_q + REV_W'(1);
                            end
                        end
                    end else begin
                        rev_cnt_q  <= '0;
                        cand_vld_q <= 1'b0;
                    end
                end
                default: state_q <= HOLDOVER;
            endcase
        end
    end

    logic                sel_valid_q;
    logic [SEC_W-1:0]    sel_sec_q;
    logic [SUBSEC_W-1:0] sel_sub_q;
    logic                fwd;

    // Forward only a good strobe from the active source while locked on it.
    assign fwd = (state_q == LOCKED) && src_ts_valid[active_q] &&
                 qual[active_q] && ts_ok[active_q];

    // Forwarded timestamp registers; seconds/subseconds hold between strobes.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            sel_valid_q <= 1'b0;
            sel_sec_q   <= '0;
            sel_sub_q   <= '0;
        end else begin
            sel_valid_q <= fwd;
            if (fwd) begin
                sel_sec_q <= sec_arr[active_q];
                sel_sub_q <= sub_arr[active_q];
            end
        end
    end

    logic [LED_DIV_W-1:0] blink_q;

    // Free-running blink divider for the holdover LED pattern.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_q + LED_DIV_W'(1);
        end
    end

    assign sel_ts_valid    = sel_valid_q;
    assign sel_seconds     = sel_sec_q;
    assign sel_subsec      = sel_sub_q;
    assign sel_index       = active_q;
    assign src_qualified   = qual;
    assign autonomous_mode = (state_q == HOLDOVER);
    assign switch_event    = switch_event_q;
    assign led_sync        = (state_q == LOCKED) || blink_q[LED_DIV_W-1];

endmodule

// File: tb/tb_pps_source_selector.sv
// Directed bench for pps_source_selector with immediate-assertion checks.
module tb_pps_source_selector;

    localparam int NUM_SRC        = 4;
    localparam int SEC_W          = 40;
    localparam int SUBSEC_W       = 32;
    localparam int QUAL_COUNT     = 4;
    localparam int TIMEOUT_CYC    = 1000;
    localparam int SWITCH_HOLDOFF = 3;
    localparam int LED_DIV_W      = 4;
    localparam int IDX_W          = 2;

    logic                        clk_100mhz = 1'b0;
    logic                        rst_n = 1'b0;
    logic [NUM_SRC-1:0]          src_ts_valid = '0;
    logic [NUM_SRC*SEC_W-1:0]    src_seconds;
    logic [NUM_SRC*SUBSEC_W-1:0] src_subsec;
    logic [NUM_SRC-1:0]          src_sync_locked = '1;
    logic [NUM_SRC-1:0]          src_enable = '1;
    logic                        force_autonomous = 1'b0;
    logic                        sel_ts_valid;
    logic [SEC_W-1:0]            sel_seconds;
    logic [SUBSEC_W-1:0]         sel_subsec;
    logic [IDX_W-1:0]            sel_index;
    logic [NUM_SRC-1:0]          src_qualified;
    logic                        autonomous_mode;
    logic                        switch_event;
    logic                        led_sync;

    logic [SEC_W-1:0]    sec_v [NUM_SRC];
    logic [SUBSEC_W-1:0] sub_v [NUM_SRC];
    logic [SEC_W-1:0]    max_sec;

    int checks = 0;
    int errors = 0;
    int sw_cnt = 0;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_pack
        assign src_seconds[g*SEC_W +: SEC_W]       = sec_v[g];
        assign src_subsec[g*SUBSEC_W +: SUBSEC_W] = sub_v[g];
    end

    pps_source_selector #(
        .NUM_SRC        (NUM_SRC),
        .SEC_W          (SEC_W),
        .SUBSEC_W       (SUBSEC_W),
        .QUAL_COUNT     (QUAL_COUNT),
        .TIMEOUT_CYC    (TIMEOUT_CYC),
        .SWITCH_HOLDOFF (SWITCH_HOLDOFF),
        .LED_DIV_W      (LED_DIV_W)
    ) dut (
        .clk_100mhz       (clk_100mhz),
        .rst_n            (rst_n),
        .src_ts_valid     (src_ts_valid),
        .src_seconds      (src_seconds),
        .src_subsec       (src_subsec),
        .src_sync_locked  (src_sync_locked),
        .src_enable       (src_enable),
        .force_autonomous (force_autonomous),
        .sel_ts_valid     (sel_ts_valid),
        .sel_seconds      (sel_seconds),
        .sel_subsec       (sel_subsec),
        .sel_index        (sel_index),
        .src_qualified    (src_qualified),
        .autonomous_mode  (autonomous_mode),
        .switch_event     (switch_event),
        .led_sync         (led_sync)
    );

    // Clock: 100 MHz, period 10.
    always #5 clk_100mhz = ~clk_100mhz;

    // Count switch_event pulses away from the active edge.
    always @(negedge clk_100mhz) begin
        if (rst_n && switch_event) sw_cnt++;
    end

    // Run-time bound.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100mhz);
        #1;
    endtask

    // One-cycle strobe on every source in mask, using current sec_v/sub_v.
    task automatic strobe(input logic [NUM_SRC-1:0] mask);
        @(posedge clk_100mhz);
        #1 src_ts_valid = mask;
        @(posedge clk_100mhz);
        #1 src_ts_valid = '0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic saw_hi;
        logic saw_lo;
        max_sec = '1;
        for (int i = 0; i < NUM_SRC; i++) begin
            sec_v[i] = '0;
            sub_v[i] = '0;
        end

        // Reset values
        tick(1);
        check("rst_valid", sel_ts_valid, 0);
        check("rst_sec", sel_seconds, 0);
        check("rst_sub", sel_subsec, 0);
        check("rst_idx", sel_index, 0);
        check("rst_qual", src_qualified, 0);
        check("rst_auto", autonomous_mode, 1);
        check("rst_sw", switch_event, 0);
        check("rst_led", led_sync, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // Source 2 alone: 100..104, qualifies on 103, 104 forwarded
        for (int k = 0; k < 5; k++) begin
            sec_v[2] = SEC_W'(100 + k);
            sub_v[2] = SUBSEC_W'(k * 10);
            strobe(4'b0100);
            if (k < 4) check("s1_no_fwd", sel_ts_valid, 0);
            if (k == 3) begin
                check("s1_qual", src_qualified, 4'b0100);
                check("s1_auto_pre", autonomous_mode, 1);
                tick(1);
                check("s1_auto_post", autonomous_mode, 0);
                check("s1_idx", sel_index, 2);
                check("s1_sw", switch_event, 1);
                tick(1);
                check("s1_sw_clear", switch_event, 0);
                check("s1_led", led_sync, 1);
            end
            if (k == 4) begin
                check("s1_fwd_valid", sel_ts_valid, 1);
                check("s1_fwd_sec", sel_seconds, 104);
                check("s1_fwd_sub", sel_subsec, 40);
                tick(1);
                check("s1_valid_drop", sel_ts_valid, 0);
                check("s1_sec_hold", sel_seconds, 104);
            end
            tick(497);
        end
        check("s1_sw_once", sw_cnt, 1);

        // Source 0 joins: qualifies on 203, revertive switch after 206
        for (int k = 0; k < 8; k++) begin
            sec_v[0] = SEC_W'(200 + k);
            sub_v[0] = 32'hA000_0000 + SUBSEC_W'(k);
            sec_v[2] = SEC_W'(105 + k);
            sub_v[2] = SUBSEC_W'(k);
            strobe(4'b0101);
            check("s2_valid", sel_ts_valid, 1);
            if (k <= 6) check("s2_sec_src2", sel_seconds, 105 + k);
            if (k == 3) check("s2_qual", src_qualified, 4'b0101);
            if (k == 5) check("s2_no_early", sel_index, 2);
            if (k == 6) begin
                check("s2_idx_pre", sel_index, 2);
                tick(1);
                check("s2_idx_post", sel_index, 0);
                check("s2_sw", switch_event, 1);
            end
            if (k == 7) begin
                check("s2_sec_src0", sel_seconds, 207);
                check("s2_sub_src0", sel_subsec, 32'hA000_0007);
            end
            if (k < 7) tick(497);
        end

        // Source 0 goes silent: timeout, immediate failover to source 2
        tick(499);
        sec_v[2] = 40'd113;
        strobe(4'b0100);
        tick(498);
        check("s3_qual_999", src_qualified, 4'b0101);
        tick(1);
        check("s3_qual_1000", src_qualified, 4'b0101);
        tick(1);
        check("s3_qual_tmo", src_qualified, 4'b0100);
        check("s3_idx_pre", sel_index, 0);
        tick(1);
        check("s3_idx_post", sel_index, 2);
        check("s3_sw", switch_event, 1);
        check("s3_auto", autonomous_mode, 0);
        sec_v[2] = 40'd114;
        strobe(4'b0100);
        check("s3_fwd_valid", sel_ts_valid, 1);
        check("s3_fwd_sec", sel_seconds, 114);

        // Everything silent: holdover and blinking LED
        tick(1001);
        check("s3_all_unqual", src_qualified, 0);
        check("s3_auto_pre", autonomous_mode, 0);
        tick(1);
        check("s3_holdover", autonomous_mode, 1);
        check("s3_hold_sw", switch_event, 1);
        check("s3_idx_hold", sel_index, 2);
        saw_hi = 1'b0;
        saw_lo = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_100mhz);
            if (led_sync) saw_hi = 1'b1;
            else saw_lo = 1'b1;
        end
        check("s3_led_blink", {saw_hi, saw_lo}, 2'b11);

        // Source 1: 47..50 qualifies, jump to 52 disqualifies and restarts at 1
        for (int s = 47; s <= 50; s++) begin
            tick(20);
            sec_v[1] = SEC_W'(s);
            strobe(4'b0010);
        end
        check("s4_qual", src_qualified, 4'b0010);
        tick(1);
        check("s4_locked", autonomous_mode, 0);
        check("s4_idx", sel_index, 1);
        check("s4_sw", switch_event, 1);
        tick(20);
        sec_v[1] = 40'd52;
        strobe(4'b0010);
        check("s4_jump_no_fwd", sel_ts_valid, 0);
        check("s4_jump_sec_hold", sel_seconds, 114);
        check("s4_jump_unqual", src_qualified, 0);
        tick(1);
        check("s4_jump_holdover", autonomous_mode, 1);
        for (int s = 53; s <= 54; s++) begin
            tick(20);
            sec_v[1] = SEC_W'(s);
            strobe(4'b0010);
        end
        check("s4_restart_cnt3", src_qualified, 0);
        tick(20);
        sec_v[1] = 40'd55;
        strobe(4'b0010);
        check("s4_restart_cnt4", src_qualified, 4'b0010);

        // Enable mask drop, then seconds wrap on source 1
        src_enable = 4'b1101;
        tick(1);
        check("s5_disable", src_qualified, 0);
        src_enable = 4'b1111;
        tick(2);
        for (int i = 3; i >= 0; i--) begin
            tick(20);
            sec_v[1] = max_sec - SEC_W'(i);
            strobe(4'b0010);
        end
        check("s5_qual_max", src_qualified, 4'b0010);
        tick(1);
        check("s5_locked", autonomous_mode, 0);
        check("s5_idx", sel_index, 1);
        tick(20);
        sec_v[1] = '0;
        sub_v[1] = 32'h1234_5678;
        strobe(4'b0010);
        check("s5_wrap_valid", sel_ts_valid, 1);
        check("s5_wrap_sec", sel_seconds, 0);
        check("s5_wrap_sub", sel_subsec, 32'h1234_5678);
        check("s5_wrap_qual", src_qualified, 4'b0010);

        // force_autonomous while locked
        force_autonomous = 1'b1;
        tick(1);
        check("s6_force_auto", autonomous_mode, 1);
        check("s6_force_sw", switch_event, 1);
        tick(5);
        sec_v[1] = 40'd1;
        strobe(4'b0010);
        check("s6_force_no_fwd", sel_ts_valid, 0);
        check("s6_force_sec_hold", sel_seconds, 0);
        force_autonomous = 1'b0;
        tick(1);
        check("s6_release_auto", autonomous_mode, 0);
        check("s6_release_sw", switch_event, 1);
        check("s6_release_idx", sel_index, 1);
        tick(5);
        sec_v[1] = 40'd2;
        strobe(4'b0010);
        check("s6_fwd_valid", sel_ts_valid, 1);
        check("s6_fwd_sec", sel_seconds, 2);

        // Asynchronous reset mid-cycle
        #3 rst_n = 1'b0;
        #1;
        check("s7_rst_valid", sel_ts_valid, 0);
        check("s7_rst_sec", sel_seconds, 0);
        check("s7_rst_sub", sel_subsec, 0);
        check("s7_rst_idx", sel_index, 0);
        check("s7_rst_qual", src_qualified, 0);
        check("s7_rst_auto", autonomous_mode, 1);
        check("s7_rst_sw", switch_event, 0);
        check("s7_rst_led", led_sync, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
